// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and
// the single-byte command codes understood by the Segway power-up logic.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned BAUD_DIV = 2604;
    localparam logic [7:0]  CMD_GO   = 8'h47;
    localparam logic [7:0]  CMD_STOP = 8'h53;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-timing down-counter. tick marks the cycle whose clock edge
// takes the count to zero, so a load of N yields a sample N edges later.
module uart_baud_cnt #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tick
);

    logic [W-1:0] cnt_r;

    // Count register: load has priority, then decrement while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = en & (cnt_r == W'(1));

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for the BLE command stream: byte handshake, framing and
// overrun flags, and go/stop strobes for the power-up command bytes.
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = uart_pkg::BAUD_DIV,
    parameter logic [7:0]  CMD_GO   = uart_pkg::CMD_GO,
    parameter logic [7:0]  CMD_STOP = uart_pkg::CMD_STOP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err,
    output logic       go,
    output logic       stop
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2);

    logic             rx_meta_r, rx_s, rx_q;
    logic [1:0]       flush_r;
    logic             armed_r;
    logic             fall_s;
    rx_state_t        state_r, state_nxt_s;
    logic [7:0]       shift_r;
    logic [2:0]       bit_cnt_r;
    logic             baud_load_s, baud_en_s, baud_tick_s;
    logic [CNT_W-1:0] baud_val_s;
    logic             shift_en_s, bit_clr_s, good_byte_s, bad_byte_s;
    logic [7:0]       rx_data_r;
    logic             rdy_r, frm_err_r, ovr_err_r, go_r, stop_r;

    // Synchronizer resets high; armed_r waits for a real high sample so a
    // line held low through reset is not taken as a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
            rx_q      <= 1'b1;
            flush_r   <= 2'b00;
            armed_r   <= 1'b0;
        end else begin
            rx_meta_r <= RX;
            rx_s      <= rx_meta_r;
            rx_q      <= rx_s;
            flush_r   <= {flush_r[0], 1'b1};
            armed_r   <= armed_r | (flush_r[1] & rx_s);
        end
    end

    assign fall_s    = armed_r & rx_q & ~rx_s;
    assign baud_en_s = (state_r != IDLE);

    uart_baud_cnt #(
        .W (CNT_W)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .load     (baud_load_s),
        .load_val (baud_val_s),
        .en       (baud_en_s),
        .tick     (baud_tick_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath controls.
    always_comb begin
        state_nxt_s = state_r;
        baud_load_s = 1'b0;
        baud_val_s  = FULL_BIT;
        shift_en_s  = 1'b0;
        bit_clr_s   = 1'b0;
        good_byte_s = 1'b0;
        bad_byte_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    baud_load_s = 1'b1;
                    baud_val_s  = HALF_BIT;
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (baud_tick_s && !rx_s) begin
                    baud_load_s = 1'b1;
                    bit_clr_s   = 1'b1;
                    state_nxt_s = DATA;
                end else if (baud_tick_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (baud_tick_s) begin
                    shift_en_s  = 1'b1;
                    baud_load_s = 1'b1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s = STOP;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            STOP: begin
                if (baud_tick_s) begin
                    good_byte_s = rx_s;
                    bad_byte_s  = ~rx_s;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Shift register and data-bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
        end else begin
            if (shift_en_s) begin
                shift_r <= {rx_s, shift_r[7:1]};
            end
            if (bit_clr_s) begin
                bit_cnt_r <= 3'd0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end
    end

    // Delivered byte, handshake and error/command flags; a completing byte
    // beats a coincident clr_rdy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_r <= 8'h00;
            rdy_r     <= 1'b0;
            ovr_err_r <= 1'b0;
            frm_err_r <= 1'b0;
            go_r      <= 1'b0;
            stop_r    <= 1'b0;
        end else begin
            frm_err_r <= bad_byte_s;
            go_r      <= good_byte_s & (shift_r == CMD_GO);
            stop_r    <= good_byte_s & (shift_r == CMD_STOP);
            if (good_byte_s) begin
                rx_data_r <= shift_r;
                rdy_r     <= 1'b1;
                ovr_err_r <= (ovr_err_r | rdy_r) & ~clr_rdy;
            end else if (clr_rdy) begin
                rdy_r     <= 1'b0;
                ovr_err_r <= 1'b0;
            end
        end
    end

    assign rx_data = rx_data_r;
    assign rdy     = rdy_r;
    assign frm_err = frm_err_r;
    assign ovr_err = ovr_err_r;
    assign go      = go_r;
    assign stop    = stop_r;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at a shortened bit time; frames are driven
// on falling clock edges and outputs are sampled on falling edges.
module tb_uart_cmd_rx;

    localparam int BD  = 32;
    localparam int H   = BD / 2;
    localparam int LAT = 3 + H + 9 * BD;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy, frm_err, ovr_err, go, stop;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int go_tot = 0, stop_tot = 0, frm_tot = 0, both_tot = 0;
    int rdy_rise_cyc = 0;
    logic rdy_d = 1'b0;
    int g0, s0, f0, lat, t_fall;

    uart_cmd_rx #(
        .BAUD_DIV (BD),
        .CMD_GO   (8'h47),
        .CMD_STOP (8'h53)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .ovr_err (ovr_err),
        .go      (go),
        .stop    (stop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        go_tot   <= go_tot + (go ? 1 : 0);
        stop_tot <= stop_tot + (stop ? 1 : 0);
        frm_tot  <= frm_tot + (frm_err ? 1 : 0);
        both_tot <= both_tot + ((go && stop) ? 1 : 0);
        if (rdy && !rdy_d) rdy_rise_cyc <= cyc;
        rdy_d <= rdy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sb);
        RX = 1'b0;
        fall_cyc = cyc;
        idle(BD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            idle(BD);
        end
        RX = sb;
        idle(BD);
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        idle(1);
        clr_rdy = 1'b0;
    endtask

    task automatic snap();
        g0 = go_tot;
        s0 = stop_tot;
        f0 = frm_tot;
    endtask

    initial begin
        rst = 1'b1;
        RX = 1'b1;
        clr_rdy = 1'b0;
        idle(5);
        check("rst_rdy", 32'(rdy), 32'h0);
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_flags", 32'({frm_err, ovr_err, go, stop}), 32'h0);
        rst = 1'b0;
        idle(10);

        // single 'G' command
        snap();
        send_byte(8'h47, 1'b1);
        t_fall = fall_cyc;
        idle(BD);
        check("g_rdy", 32'(rdy), 32'h1);
        check("g_data", 32'(rx_data), 32'h47);
        lat = rdy_rise_cyc - t_fall;
        check("g_latency", 32'((lat >= LAT - 2 && lat <= LAT + 2) ? LAT : lat), 32'(LAT));
        check("g_go_cycles", go_tot - g0, 32'd1);
        check("g_stop_cycles", stop_tot - s0, 32'd0);
        check("g_frm_cycles", frm_tot - f0, 32'd0);
        pulse_clr();
        check("g_clr_rdy", 32'(rdy), 32'h0);

        // back-to-back 'S' then 0xA5 without acknowledge
        snap();
        send_byte(8'h53, 1'b1);
        send_byte(8'hA5, 1'b1);
        idle(BD);
        check("ss_stop_cycles", stop_tot - s0, 32'd1);
        check("ss_go_cycles", go_tot - g0, 32'd0);
        check("ss_data", 32'(rx_data), 32'hA5);
        check("ss_rdy", 32'(rdy), 32'h1);
        check("ss_ovr", 32'(ovr_err), 32'h1);
        pulse_clr();
        check("ss_clr", 32'({rdy, ovr_err}), 32'h0);

        // framing error, line held low past the stop bit
        snap();
        send_byte(8'h3C, 1'b0);
        idle(BD);
        RX = 1'b1;
        idle(2 * BD);
        check("fe_frm_cycles", frm_tot - f0, 32'd1);
        check("fe_rdy", 32'(rdy), 32'h0);
        check("fe_data", 32'(rx_data), 32'hA5);
        send_byte(8'h47, 1'b1);
        idle(BD);
        check("fe_next_data", 32'(rx_data), 32'h47);
        check("fe_next_rdy", 32'(rdy), 32'h1);
        check("fe_go_cycles", go_tot - g0, 32'd1);
        pulse_clr();

        // short low glitch is a false start
        snap();
        RX = 1'b0;
        idle(BD / 4);
        RX = 1'b1;
        idle(2 * BD);
        check("gl_rdy", 32'(rdy), 32'h0);
        check("gl_pulses", (go_tot - g0) + (stop_tot - s0) + (frm_tot - f0), 32'd0);
        send_byte(8'h55, 1'b1);
        idle(BD);
        check("gl_next_data", 32'(rx_data), 32'h55);
        check("gl_next_rdy", 32'(rdy), 32'h1);

        // reset in the middle of bit 4 of 'G', line still low afterwards
        snap();
        RX = 1'b0;
        idle(BD);
        for (int i = 0; i < 4; i++) begin
            RX = (8'h47 >> i) & 8'h01;
            idle(BD);
        end
        RX = 1'b0;
        idle(H);
        rst = 1'b1;
        idle(2);
        check("mr_rdy", 32'(rdy), 32'h0);
        check("mr_data", 32'(rx_data), 32'h0);
        check("mr_flags", 32'({frm_err, ovr_err, go, stop}), 32'h0);
        idle(8);
        rst = 1'b0;
        idle(BD);
        RX = 1'b1;
        idle(3 * BD);
        check("mr_after_rdy", 32'(rdy), 32'h0);
        check("mr_after_pulses", (go_tot - g0) + (frm_tot - f0), 32'd0);
        send_byte(8'h12, 1'b1);
        idle(BD);
        check("mr_next_data", 32'(rx_data), 32'h12);
        check("mr_next_rdy", 32'({rdy, ovr_err}), 32'h2);

        // acknowledge on the very cycle 0x81 completes while rdy is high
        fork
            send_byte(8'h81, 1'b1);
            begin
                idle(2 + H + 9 * BD);
                clr_rdy = 1'b1;
                idle(1);
                clr_rdy = 1'b0;
                check("cc_rdy", 32'(rdy), 32'h1);
                check("cc_data", 32'(rx_data), 32'h81);
                check("cc_ovr", 32'(ovr_err), 32'h0);
            end
        join
        idle(BD);
        check("go_stop_overlap", both_tot, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
